// File: rtl/fault_severity_tracker.sv
// Fault severity tracker: turns level fault flags into registered severity
// (NONE / MINOR / CRITICAL), escalates bursts of minor faults through a
// leaky counter, and keeps CRITICAL (and the halt request) latched until a
// 4-phase clear handshake runs.
module fault_severity_tracker #(
   parameter int                 NUM_SRC    = 4,
   parameter logic [NUM_SRC-1:0] CRIT_MASK  = 4'b0100,
   parameter int                 ESC_THRESH = 3,
   parameter int                 WINDOW     = 8,
   parameter int                 CNT_W      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] fault_in,
   input  logic               clr_req,
   output logic               clr_ack,
   output logic [1:0]         fault_type,
   output logic [NUM_SRC-1:0] fault_src,
   output logic [CNT_W-1:0]   minor_cnt,
   output logic               fault_valid,
   output logic               halt_req
);

   localparam int                 TMR_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W:0]     ESC_VAL  = (CNT_W + 1)'(ESC_THRESH);

   // The state encoding doubles as the fault_type output code.
   typedef enum logic [1:0] {
      ST_NONE  = 2'b00,
      ST_MINOR = 2'b01,
      ST_CRIT  = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] fault_prev_q;
   logic [NUM_SRC-1:0] src_q, src_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               ack_q, ack_d;
   logic               valid_q;
   logic               halt_q;

   logic [NUM_SRC-1:0] evt;
   logic               any_evt;
   logic               crit_evt;
   logic               min_evt;
   logic               clear_exec;
   logic               decay;
   logic [CNT_W:0]     cnt_plus1;
   logic               esc_hit;

   // Rising-edge detect per source: a held level yields a single event.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_evt
      assign evt[gi] = fault_in[gi] & ~fault_prev_q[gi];
   end

   assign any_evt    = |evt;
   assign crit_evt   = |(evt & CRIT_MASK);
   assign min_evt    = |(evt & ~CRIT_MASK);
   // A pending clear yields to any event in the same cycle; it retries next cycle.
   assign clear_exec = clr_req & ~ack_q & ~any_evt;
   // Escalation is judged on the pre-saturation count so a saturated counter still escalates.
   assign cnt_plus1  = {1'b0, cnt_q} + 1'b1;
   assign esc_hit    = (cnt_plus1 >= ESC_VAL);

   // Leaky counter, decay timer, sticky source mask and clear acknowledge.
   always_comb begin
      cnt_d   = cnt_q;
      timer_d = timer_q;
      decay   = 1'b0;
      src_d   = src_q | evt;
      ack_d   = ack_q;

      if (clear_exec) begin
         cnt_d   = '0;
         timer_d = '0;
         src_d   = '0;
      end else if (min_evt) begin
         timer_d = '0;
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (cnt_q != '0) begin
         if (timer_q == TMR_LAST) begin
            cnt_d   = cnt_q - 1'b1;
            timer_d = '0;
            decay   = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end else begin
         timer_d = '0;
      end

      if (clear_exec) begin
         ack_d = 1'b1;
      end else if (ack_q && !clr_req) begin
         ack_d = 1'b0;
      end
   end

   // Severity transitions: CRITICAL dominates and is left only through a clear.
   always_comb begin
      state_d = state_q;
      if (clear_exec) begin
         state_d = ST_NONE;
      end else if (crit_evt || (min_evt && esc_hit)) begin
         state_d = ST_CRIT;
      end else if (state_q == ST_NONE && min_evt) begin
         state_d = ST_MINOR;
      end else if (state_q == ST_MINOR && decay && cnt_d == '0) begin
         state_d = ST_NONE;
      end
   end

   // All state and outputs update together; reset clears everything, including an in-flight clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_NONE;
         fault_prev_q <= '0;
         src_q        <= '0;
         cnt_q        <= '0;
         timer_q      <= '0;
         ack_q        <= 1'b0;
         valid_q      <= 1'b0;
         halt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fault_prev_q <= fault_in;
         src_q        <= src_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
         ack_q        <= ack_d;
         valid_q      <= any_evt;
         halt_q       <= (state_d == ST_CRIT);
      end
   end

   assign fault_type  = state_q;
   assign fault_src   = src_q;
   assign minor_cnt   = cnt_q;
   assign fault_valid = valid_q;
   assign clr_ack     = ack_q;
   assign halt_req    = halt_q;

endmodule
